// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared opcode constants and helpers for the write-back stage
// Purpose: opcode encodings, register-file sizing constants and the
//          writes_reg() classifier shared by memory-control and write-back.
// Ports:   none (package).
package wb_pkg;

    localparam int NUM_REGS  = 16;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b1001;
    localparam logic [3:0] OP_STORE  = 4'b1010;
    localparam logic [3:0] OP_BRANCH = 4'b1101;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    // Every opcode outside the non-writing set produces a register result.
    function automatic logic writes_reg(input logic [3:0] op);
        return !(op == OP_NOP || op == OP_STORE || op == OP_BRANCH || op == OP_HALT);
    endfunction

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - NUM_REGS x DATA_W register array, 1 write / 2 read ports
// Purpose: architectural register storage with R0 hard-wired to zero.
// Ports:   clk, reset          - clock, async active-high reset (clears array)
//          we, waddr, wdata    - synchronous write port
//          raddr1/2, rdata1/2  - combinational read ports
module regfile_core #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr1,
    input  logic [3:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Index 0 and anything beyond the implemented array are not real storage.
    function automatic logic live_idx(input logic [3:0] idx);
        return (idx != 4'd0) && (int'(idx) < NUM_REGS);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && live_idx(waddr)) begin
            regs[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (live_idx(raddr1)) begin
            rdata1 = regs[raddr1[IDX_W-1:0]];
        end
        if (live_idx(raddr2)) begin
            rdata2 = regs[raddr2[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - write-back latch, register file, bypass, halt, retire count
// Purpose: captures the memory stage result into a one-entry latch, commits it
//          to the register file on the following edge, and serves two operands
//          with bypass from the pending latch.
// Ports:   clk, reset                       - clock, async active-high reset
//          valid_in, opcode, dest_reg,
//          alu_result, mem_data             - instruction leaving memory stage
//          src1_sel/src2_sel, source1/2     - operand read ports
//          wb_valid, wb_reg, wb_data        - pending write-back latch
//          halted, retired                  - sticky halt, retired count
module writeback_regfile #(
    parameter int NUM_REGS = wb_pkg::NUM_REGS,
    parameter int DATA_W   = wb_pkg::DATA_W,
    parameter int CNT_W    = wb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [3:0]        opcode,
    input  logic [3:0]        dest_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [3:0]        src1_sel,
    input  logic [3:0]        src2_sel,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    output logic              wb_valid,
    output logic [3:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    import wb_pkg::writes_reg;
    import wb_pkg::OP_LOAD;
    import wb_pkg::OP_HALT;

    logic              capture;
    logic              cap_write;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;

    // Once halted nothing from the memory stage is accepted until reset.
    assign capture = valid_in && !halted;

    // Writes to R0 or to unimplemented indices are dropped here so the latch
    // never advertises a bypass for a register that cannot hold the value.
    assign cap_write = capture && writes_reg(opcode) && (dest_reg != 4'd0)
                       && (int'(dest_reg) < NUM_REGS);

    assign cap_data = (opcode == OP_LOAD) ? mem_data : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            wb_valid <= cap_write;
            if (capture) begin
                wb_reg  <= dest_reg;
                wb_data <= cap_data;
                retired <= retired + 1'b1;
                if (opcode == OP_HALT) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    // The latch content commits on the edge after capture; a capture and a
    // commit in the same cycle are independent, so the older write lands
    // while the newer one waits in the latch.
    regfile_core #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_regfile_core (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_valid),
        .waddr  (wb_reg),
        .wdata  (wb_data),
        .raddr1 (src1_sel),
        .raddr2 (src2_sel),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // R0 and out-of-range indices read 0; otherwise the pending latch wins
    // over the array because it holds the younger value.
    always_comb begin
        source1 = '0;
        source2 = '0;
        if (src1_sel != 4'd0 && int'(src1_sel) < NUM_REGS) begin
            source1 = (wb_valid && wb_reg == src1_sel) ? wb_data : rf_rd1;
        end
        if (src2_sel != 4'd0 && int'(src2_sel) < NUM_REGS) begin
            source2 = (wb_valid && wb_reg == src2_sel) ? wb_data : rf_rd2;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic [3:0]  dest_reg = 4'd0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_data = '0;
    logic [3:0]  src1_sel = 4'd0;
    logic [3:0]  src2_sel = 4'd0;
    logic [31:0] source1;
    logic [31:0] source2;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        halted;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         got;
    logic        m_halted = 1'b0;
    logic [15:0] exp_retired = '0;

    writeback_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .dest_reg   (dest_reg),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .src1_sel   (src1_sel),
        .src2_sel   (src2_sel),
        .source1    (source1),
        .source2    (source2),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic logic model_writes(input logic [3:0] op);
        return !(op == 4'b1010 || op == 4'b1101 || op == 4'b0000 || op == 4'b1111);
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge and record what the model expects.
    task automatic issue(input logic [3:0] op, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem);
        valid_in   = 1'b1;
        opcode     = op;
        dest_reg   = dest;
        alu_result = alu;
        mem_data   = mem;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        opcode   = 4'b0000;
        if (!m_halted) begin
            exp_retired = exp_retired + 16'd1;
            if (model_writes(op) && dest != 4'd0) begin
                sb.push_back('{idx: dest, data: (op == 4'b1001) ? mem : alu});
            end
            if (op == 4'b1111) m_halted = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        sb.delete();
        m_halted    = 1'b0;
        exp_retired = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        issue(4'b0001, 4'd3, 32'h5, 32'h0);
        src1_sel = 4'd3;
        #1;
        checks++; if (source1 !== 32'h5) begin errors++; $display("FAIL pre_reset_bypass: got %h expected 00000005", source1); end
        // Reset arrives while dest 3 is still pending in the latch.
        reset = 1'b1;
        #2;
        sb.delete();
        exp_retired = '0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midrun_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (source1 !== 32'h0) begin errors++; $display("FAIL midrun_source1: got %h expected 0", source1); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL midrun_retired: got %0d expected 0", retired); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        checks++; if (source1 !== 32'h0) begin errors++; $display("FAIL midrun_reg3: got %h expected 0", source1); end
    endtask

    task automatic test_alu_bypass();
        src1_sel = 4'd5;
        issue(4'b0001, 4'd5, 32'hEFEFEFEF, 32'h0);
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd5) begin errors++; $display("FAIL alu_latch: got v=%b r=%0d expected v=1 r=5", wb_valid, wb_reg); end
        checks++; if (source1 !== 32'hEFEFEFEF) begin errors++; $display("FAIL alu_bypass: got %h expected efefefef", source1); end
        idle();
        got = sb.pop_front();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_clear: got %b expected 0", wb_valid); end
        checks++; if (source1 !== got.data) begin errors++; $display("FAIL alu_commit: got %h expected %h", source1, got.data); end
    endtask

    task automatic test_load_store();
        src1_sel = 4'd2;
        issue(4'b1001, 4'd2, 32'hAF, 32'hABCDABCD);
        idle();
        got = sb.pop_front();
        checks++; if (source1 !== got.data) begin errors++; $display("FAIL load_commit: got %h expected %h", source1, got.data); end
        issue(4'b1010, 4'd2, 32'h1, 32'h0);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL store_no_write: got %b expected 0", wb_valid); end
        idle();
        checks++; if (source1 !== 32'hABCDABCD) begin errors++; $display("FAIL store_reg2: got %h expected abcdabcd", source1); end
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL ls_retired: got %0d expected %0d", retired, exp_retired); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL ls_sb_leftover: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_r0_back_to_back();
        src1_sel = 4'd0;
        src2_sel = 4'd7;
        issue(4'b0010, 4'd0, 32'h1234, 32'h0);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL r0_latch: got %b expected 0", wb_valid); end
        idle();
        checks++; if (source1 !== 32'h0) begin errors++; $display("FAIL r0_read: got %h expected 0", source1); end
        issue(4'b0011, 4'd7, 32'h11, 32'h0);
        issue(4'b0011, 4'd7, 32'h22, 32'h0);
        checks++; if (source2 !== sb[sb.size()-1].data) begin errors++; $display("FAIL b2b_bypass: got %h expected %h", source2, sb[sb.size()-1].data); end
        idle();
        void'(sb.pop_front());
        got = sb.pop_front();
        checks++; if (source2 !== got.data || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_commit: got %h v=%b expected %h v=0", source2, wb_valid, got.data); end
    endtask

    task automatic test_halt();
        do_reset();
        src1_sel = 4'd4;
        issue(4'b0001, 4'd4, 32'h9, 32'h0);
        issue(4'b1111, 4'd0, 32'h0, 32'h0);
        issue(4'b0001, 4'd4, 32'h77, 32'h0);
        idle();
        got = sb.pop_front();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL halt_retired: got %0d expected %0d", retired, exp_retired); end
        checks++; if (source1 !== got.data || wb_valid !== 1'b0) begin errors++; $display("FAIL halt_reg4: got %h v=%b expected %h v=0", source1, wb_valid, got.data); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_sb_leftover: got %0d expected 0", sb.size()); end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b expected 0", halted); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        src1_sel = 4'd5;
        src2_sel = 4'd7;
        for (int i = 0; i < 65535; i++) begin
            issue(4'b0000, 4'(i), 32'(i), 32'h0);
        end
        checks++; if (retired !== 16'hFFFF || retired !== exp_retired) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", retired); end
        issue(4'b0000, 4'd5, 32'hDEAD, 32'h0);
        checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", retired); end
        checks++; if (source1 !== 32'h0 || source2 !== 32'h0 || wb_valid !== 1'b0) begin errors++; $display("FAIL wrap_regs: got s1=%h s2=%h v=%b expected 0 0 0", source1, source2, wb_valid); end
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_load_store();
        test_r0_back_to_back();
        test_halt();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage plus architectural register file, directly downstream of the memory-control stage.
- Captures the memory stage's result (load data or ALU result) into a one-entry write-back latch, then commits it to a 16 x 32-bit register file on the following clock.
- Supplies the two source operands (source1, source2) for the next instructions, with bypass from the pending write-back latch.
- Tracks a sticky halt and a retired-instruction counter.

Parameters:
- NUM_REGS, 16, number of architectural registers; index width is clog2(NUM_REGS).
- DATA_W, 32, register and data width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  memory stage presents a valid instruction this cycle.
- opcode  input  4  opcode of the instruction leaving the memory stage.
- dest_reg  input  4  destination register index.
- alu_result  input  DATA_W  ALU result forwarded through the memory stage.
- mem_data  input  DATA_W  register_data output of the memory-control stage (load data).
- src1_sel  input  4  read index for operand 1.
- src2_sel  input  4  read index for operand 2.
- source1  output  DATA_W  operand 1 read data.
- source2  output  DATA_W  operand 2 read data.
- wb_valid  output  1  write-back latch holds a committing write.
- wb_reg  output  4  index held in the write-back latch.
- wb_data  output  DATA_W  data held in the write-back latch.
- halted  output  1  sticky; set by HALT.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- Opcode classes:
  - LOAD 4'b1001 writes mem_data.
  - STORE 4'b1010, BRANCH 4'b1101, NOP 4'b0000 and HALT 4'b1111 write nothing.
  - Every other opcode writes alu_result.
- Reset (asynchronous):
  - All registers = 0; wb_valid = 0, wb_reg = 0, wb_data = 0, halted = 0, retired = 0.
  - source1 and source2 therefore read 0.
- Cycle N, valid_in = 1, not halted:
  - Latch captures wb_valid = writes(opcode) && dest_reg != 0, plus wb_reg and selected wb_data.
  - retired increments by 1, including for non-writing opcodes and HALT itself.
  - retired wraps from 2^CNT_W-1 to 0.
- Cycle N+1 edge: if wb_valid, regs[wb_reg] <= wb_data. Latency from input to architectural state is 2 edges.
- valid_in = 0 or halted = 1: the latch loads wb_valid = 0, and retired holds.
- HALT with valid_in = 1:
  - halted goes to 1 on that edge.
  - All later inputs are ignored until reset.
  - A write already in the latch still commits on the next edge.
- Register 0 always reads 0; writes to it are dropped at capture.
- Reads are combinational.
  - source1 = 0 if src1_sel == 0.
  - Otherwise source1 = wb_data if wb_valid && wb_reg == src1_sel (bypass).
  - Otherwise source1 = regs[src1_sel].
  - source2 uses the same rule with src2_sel.
- Simultaneous events: a new capture and a commit in the same cycle are independent. If both target the same register, the older value commits and the newer one sits in the latch, so the bypass returns the newer value.
- Reset mid-operation: a pending latch write is discarded. It must not reach the register file.
- Indices ≥ NUM_REGS (when NUM_REGS < 16) are ignored for writes and read as 0.

Decomposition:
- Shared package wb_pkg holds:
  - Opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_BRANCH, OP_HALT.
  - Function writes_reg(opcode).
  - DATA_W and REG_IDX_W constants.
- The memory-control stage and its bench reuse these opcode constants.
- One natural sub-module: regfile_core. It holds the NUM_REGS x DATA_W array, one synchronous write port, two asynchronous read ports, and R0 forced to zero.
- The top level holds the write-back latch, the bypass muxes, halt and the counter.

Test Plan:
- Reset: assert reset mid-run with a write pending (dest 3, alu 32'h5) -> wb_valid = 0, regs[3] = 0, source1 = 0 with src1_sel = 3, retired = 0.
- ALU write and bypass: opcode 4'b0001, dest 5, alu_result 32'hEFEFEFEF.
  - Edge 1: source1(sel 5) = EFEFEFEF via bypass.
  - Edge 2: wb_valid = 0 and source1 still EFEFEFEF, now from the register file.
- Load vs store:
  - LOAD dest 2, mem_data 32'hABCDABCD, alu 32'hAF -> regs[2] = ABCDABCD.
  - STORE dest 2, alu 32'h1 -> regs[2] unchanged; retired increments both times.
- R0 and back-to-back same destination:
  - Write 32'h1234 to R0 -> source1(sel 0) = 0.
  - Two consecutive writes to R7 (0x11, then 0x22) -> after the second edge source2(sel 7) = 0x22.
  - After the third edge regs[7] = 0x22.
- Halt:
  - Sequence ALU dest 4 = 0x9; HALT; ALU dest 4 = 0x77 -> regs[4] = 0x9, halted = 1, retired = 2.
  - After reset, halted = 0.
- Counter wrap: preload by issuing 65535 NOPs, then one more -> retired = 0, no register changes.
